// File: rtl/regdump_pkg.sv
// Shared types and default sizes for the register-file dump engine.
// The processor register-file width constants below are reused by the dump engine.
package regdump_pkg;

   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_DATA_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_SEND,
      ST_SUM,
      ST_DONE
   } state_e;

endpackage

// File: rtl/regfile_dump.sv
// Walks register-file addresses 0..NUM_REGS-1 and streams (addr, data) beats over valid/ready.
// Optional trailing XOR-checksum beat is compiled in with REGDUMP_CHECKSUM_EN.
module regfile_dump
   import regdump_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] oaddr_q, oaddr_d;
   logic [DATA_W-1:0] odata_q, odata_d;
   logic              last_q, last_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef REGDUMP_CHECKSUM_EN
   logic [DATA_W-1:0] xsum_q, xsum_d;
   logic              sum_pres_q, sum_pres_d;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      oaddr_d = oaddr_q;
      odata_d = odata_q;
      last_d  = last_q;
`ifdef REGDUMP_CHECKSUM_EN
      xsum_d     = xsum_q;
      sum_pres_d = sum_pres_q;
`endif
      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
`ifdef REGDUMP_CHECKSUM_EN
            xsum_d = '0;
`endif
            if (start) state_d = ST_READ;
         end
         ST_READ: begin
            // Capture takes the pre-edge read value; a same-edge write is not seen.
            oaddr_d = idx_q;
            odata_d = rd_data;
`ifdef REGDUMP_CHECKSUM_EN
            last_d = 1'b0;
            xsum_d = xsum_q ^ rd_data;
`else
            last_d = (idx_q == LAST_IDX);
`endif
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                  state_d = ST_SUM;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_READ;
               end
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         ST_SUM: begin
            // First SUM cycle loads the checksum beat, second onward presents it.
            if (!sum_pres_q) begin
               sum_pres_d = 1'b1;
               oaddr_d    = '0;
               odata_d    = xsum_q;
               last_d     = 1'b1;
            end else if (out_ready) begin
               sum_pres_d = 1'b0;
               state_d    = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            idx_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      valid_d = (state_d == ST_SEND);
`ifdef REGDUMP_CHECKSUM_EN
      valid_d = valid_d | ((state_d == ST_SUM) & sum_pres_d);
`endif
      if (!valid_d) last_d = 1'b0;
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         oaddr_q <= '0;
         odata_q <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
         xsum_q     <= '0;
         sum_pres_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         oaddr_q <= oaddr_d;
         odata_q <= odata_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
         xsum_q     <= xsum_d;
         sum_pres_q <= sum_pres_d;
`endif
      end
   end

   assign rd_addr   = idx_q;
   assign out_valid = valid_q;
   assign out_addr  = oaddr_q;
   assign out_data  = odata_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
